// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan sampler.
// Channel count and select width are fixed by the mux it drives.
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    typedef logic [NUM_CH-1:0] ch_mask_t;

endpackage

// File: rtl/next_ch_finder.sv
// Finds the next enabled channel above cur, or the lowest enabled
// channel when first is set; none_left flags that no channel qualifies.
module next_ch_finder
    import mux_scan_pkg::*;
(
    input  ch_mask_t         mask,
    input  logic [SEL_W-1:0] cur,
    input  logic             first,
    output logic [SEL_W-1:0] nxt,
    output logic             none_left
);

    // Descending walk so the lowest qualifying channel is written last.
    always_comb begin
        nxt       = '0;
        none_left = 1'b1;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mask[k] && (first || (SEL_W'(k) > cur))) begin
                nxt       = SEL_W'(k);
                none_left = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_scan_sampler.sv
// Time-division scanner: steps the 4:1 mux select over enabled channels,
// holds each for dwell+1 cycles and assembles the samples into a frame.
module mux_scan_sampler
    import mux_scan_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NUM_CH-1:0]  ch_mask,
    input  logic               y_in,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic [NUM_CH-1:0]  frame,
    output logic               frame_valid
);

    state_t             state;
    ch_mask_t           mask_q;
    ch_mask_t           shadow;
    ch_mask_t           frame_nxt;
    ch_mask_t           find_mask;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt;
    logic               idle;
    logic [SEL_W-1:0]   nxt_ch;
    logic               none_left;

    assign idle      = (state == IDLE);
    assign find_mask = idle ? ch_mask : mask_q;

    // In IDLE the finder picks the first channel of the incoming mask;
    // in SCAN it advances past sel within the latched mask.
    next_ch_finder u_find (
        .mask      (find_mask),
        .cur       (sel),
        .first     (idle),
        .nxt       (nxt_ch),
        .none_left (none_left)
    );

    always_comb begin
        frame_nxt      = shadow;
        frame_nxt[sel] = y_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= '0;
            busy        <= 1'b0;
            frame       <= '0;
            frame_valid <= 1'b0;
            mask_q      <= '0;
            dwell_q     <= '0;
            cnt         <= '0;
            shadow      <= '0;
        end else begin
            frame_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (ch_mask != '0) begin
                            mask_q  <= ch_mask;
                            dwell_q <= dwell;
                            sel     <= nxt_ch;
                            cnt     <= dwell;
                            shadow  <= '0;
                            busy    <= 1'b1;
                            state   <= SCAN;
                        end else begin
                            frame       <= '0;
                            frame_valid <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - DWELL_W'(1);
                    end else begin
                        shadow[sel] <= y_in;
                        if (!none_left) begin
                            sel <= nxt_ch;
                            cnt <= dwell_q;
                        end else begin
                            frame       <= frame_nxt;
                            frame_valid <= 1'b1;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Scoreboard bench for mux_scan_sampler with a behavioural 4:1 mux.
// Edges are counted; each scan's timing is measured from its start edge.
module tb_mux_scan_sampler;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] dwell;
    logic [3:0]    ch_mask;
    logic          y_in;
    logic [1:0]    sel;
    logic          busy;
    logic [3:0]    frame;
    logic          frame_valid;
    logic [3:0]    mux_i;

    always #5 clk = ~clk;

    assign y_in = mux_i[sel];

    mux_scan_sampler #(.DWELL_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dwell       (dwell),
        .ch_mask     (ch_mask),
        .y_in        (y_in),
        .sel         (sel),
        .busy        (busy),
        .frame       (frame),
        .frame_valid (frame_valid)
    );

    typedef struct {
        logic [3:0] frame;
        int         e0;
        int         lat;
        logic [3:0] mask;
        int         dw;
    } exp_t;

    exp_t       sb[$];
    int         ecnt  = 0;
    int         n_vec = 0;
    int         n_bad = 0;
    logic [3:0] held_frame = 4'b0;
    logic [1:0] idle_sel   = 2'b0;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)",
                     nm, act, exp, ecnt);
        end
    endtask

    function automatic int nth_ch(input logic [3:0] msk, input int j);
        int c;
        int r;
        c = 0;
        r = -1;
        for (int k = 0; k < 4; k++) begin
            if (msk[k]) begin
                if (c == j) r = k;
                c++;
            end
        end
        return r;
    endfunction

    function automatic int top_ch(input logic [3:0] msk);
        int r;
        r = 0;
        for (int k = 0; k < 4; k++) if (msk[k]) r = k;
        return r;
    endfunction

    // Channel j (ascending) is sampled (j+1)*(d+1) edges after the start
    // edge; the mux input switches from ib to ia right after edge toff.
    task automatic push_exp(input logic [3:0] msk, input int d,
                            input logic [3:0] ib, input logic [3:0] ia,
                            input int toff, output int lat);
        exp_t e;
        int   j;
        int   off;
        j       = 0;
        e.frame = 4'b0;
        for (int k = 0; k < 4; k++) begin
            if (msk[k]) begin
                j++;
                off        = j * (d + 1);
                e.frame[k] = (off > toff) ? ia[k] : ib[k];
            end
        end
        e.lat  = j * (d + 1);
        e.e0   = ecnt + 1;
        e.mask = msk;
        e.dw   = d;
        sb.push_back(e);
        lat = e.lat;
    endtask

    // Called just after a falling edge; returns in the frame_valid cycle.
    task automatic run_scan(input logic [3:0] msk, input int d,
                            input logic [3:0] ib, input logic [3:0] ia,
                            input int toff, input int mid);
        int lat;
        mux_i   = ib;
        ch_mask = msk;
        dwell   = d[DW-1:0];
        start   = 1'b1;
        push_exp(msk, d, ib, ia, toff, lat);
        for (int m = 0; m < lat; m++) begin
            @(negedge clk);
            start   = (m == mid);
            ch_mask = 4'($urandom);
            dwell   = DW'($urandom);
            if (m == toff) mux_i = ia;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    always @(posedge clk) begin
        int m;
        #1;
        if (sb.size() > 0 && ecnt >= sb[0].e0) begin
            m = ecnt - sb[0].e0;
            if (m < sb[0].lat) begin
                chk("busy_scan", busy, 1);
                chk("sel_scan", sel, nth_ch(sb[0].mask, m / (sb[0].dw + 1)));
                chk("fv_scan", frame_valid, 0);
            end else begin
                chk("frame_valid", frame_valid, 1);
                chk("frame", frame, sb[0].frame);
                chk("busy_done", busy, 0);
                held_frame = sb[0].frame;
                if (sb[0].mask != 4'b0) idle_sel = 2'(top_ch(sb[0].mask));
                void'(sb.pop_front());
            end
        end else begin
            chk("fv_idle", frame_valid, 0);
            chk("busy_idle", busy, 0);
            chk("frame_held", frame, held_frame);
            chk("sel_idle", sel, idle_sel);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] msk;
        logic [3:0] ib;
        logic [3:0] ia;
        int         d;
        int         toff;
        int         mid;
        int         lat;
        rst     = 1'b1;
        start   = 1'b0;
        ch_mask = 4'b0;
        dwell   = '0;
        mux_i   = 4'b0;
        repeat (3) @(negedge clk);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame", frame, 0);
        chk("rst_fv", frame_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        run_scan(4'hF, 0, 4'b1010, 4'b1010, 1000, -1);
        run_scan(4'b0101, 2, 4'hF, 4'hF, 1000, -1);
        run_scan(4'b0000, 5, 4'hF, 4'hF, 1000, -1);
        repeat (2) @(negedge clk);
        run_scan(4'hF, 1, 4'b0110, 4'b0110, 1000, 3);
        run_scan(4'b0110, 0, 4'b1101, 4'b1101, 1000, 0);
        run_scan(4'b1001, 1, 4'b1001, 4'b1001, 1000, -1);
        run_scan(4'hF, 3, 4'b0000, 4'b1111, 3, -1);
        run_scan(4'hF, 3, 4'b0000, 4'b1111, 4, -1);
        run_scan(4'b1000, 15, 4'b1000, 4'b1000, 1000, -1);
        run_scan(4'b1000, 15, 4'b0111, 4'b0111, 1000, -1);
        run_scan(4'b0011, 0, 4'b0011, 4'b0011, 1000, -1);

        mux_i   = 4'b0110;
        ch_mask = 4'hF;
        dwell   = 4'd3;
        start   = 1'b1;
        push_exp(4'hF, 3, 4'b0110, 4'b0110, 1000, lat);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        idle_sel   = 2'b0;
        held_frame = 4'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_sel", sel, 0);
        chk("abort_busy", busy, 0);
        chk("abort_frame", frame, 0);
        chk("abort_fv", frame_valid, 0);
        repeat (20) @(negedge clk);

        run_scan(4'b1100, 0, 4'b0100, 4'b0100, 1000, -1);
        rst     = 1'b1;
        start   = 1'b1;
        ch_mask = 4'hF;
        dwell   = 4'd2;
        idle_sel   = 2'b0;
        held_frame = 4'b0;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("rststart_busy", busy, 0);
        chk("rststart_sel", sel, 0);
        chk("rststart_fv", frame_valid, 0);
        repeat (4) @(negedge clk);

        for (int t = 0; t < 40; t++) begin
            msk  = 4'($urandom);
            ib   = 4'($urandom);
            ia   = 4'($urandom);
            d    = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 4));
            toff = int'($urandom_range(0, 40));
            mid  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30)) : -1;
            run_scan(msk, d, ib, ia, toff, mid);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_scan_sampler.md
Name: mux_scan_sampler

Overview:
- Time-division scanner that sits directly upstream and downstream of the 4:1 mux.
- Drives the mux select and samples the mux's single-bit output back in.
- Walks a latched set of enabled channels, holding each select for a programmable dwell, and assembles the samples into a 4-bit frame.
- Lets one-bit mux output be turned into a parallel snapshot of all four inputs.

Parameters:
- DWELL_W, 4: width of the dwell count. Each channel is held for dwell+1 cycles.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request a scan; sampled only in IDLE.
- dwell  in  DWELL_W  extra hold cycles per channel; latched on accepted start.
- ch_mask  in  4  channel enables, bit k = channel k; latched on accepted start.
- y_in  in  1  mux output Y, combinational from sel.
- sel  out  2  mux select s (registered).
- busy  out  1  high while scanning.
- frame  out  4  bit k = sample of channel k; masked bits are 0. Held until next frame_valid.
- frame_valid  out  1  one-cycle pulse when frame is updated.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: sel=0, busy=0, frame=0, frame_valid=0, state=IDLE, internal counters/shadow=0.
- States: IDLE, SCAN.
- IDLE:
  - sel holds its last value; frame_valid is forced 0 except for the pulse below.
  - On start with ch_mask!=0:
    - Latch mask and dwell.
    - sel <= lowest enabled channel; cnt <= dwell; shadow <= 0; busy <= 1; go to SCAN.
  - On start with ch_mask==0: frame <= 0, frame_valid <= 1 for one cycle; busy stays 0; stay in IDLE.
- SCAN, each edge:
  - If cnt!=0: cnt <= cnt-1.
  - If cnt==0: shadow[sel] <= y_in (the sample).
    - If a higher enabled channel remains: sel <= next enabled channel (ascending, no wrap); cnt <= latched dwell.
    - Otherwise: frame <= shadow with bit sel replaced by y_in; frame_valid <= 1; busy <= 0; go to IDLE.
- Latency:
  - With N enabled channels, frame_valid is high in the cycle N*(dwell+1) cycles after the cycle in which start was high.
  - Example: N=4, dwell=0 gives 4 cycles.
- Sampling: y_in is sampled on the last edge of each channel's hold. sel has been stable for at least one full cycle before that edge, so the mux path gets one full cycle.
- Masked channels are never selected; their frame bits are 0.
- start while busy: ignored (no queueing). Changes to dwell or ch_mask during SCAN have no effect.
- Back-to-back: the cycle with frame_valid=1 is in IDLE, so start in that cycle is accepted.
- dwell at maximum (2^DWELL_W-1): the counter must not wrap early; hold is exactly 2^DWELL_W cycles.
- rst mid-scan: immediate return to reset values. No frame_valid, and frame is cleared to 0.
- rst and start in the same cycle: rst wins.

Decomposition:
- Shared package mux_scan_pkg:
  - NUM_CH=4, SEL_W=2.
  - State enum typedef {IDLE, SCAN}.
  - Channel-mask typedef logic [NUM_CH-1:0].
- One natural sub-module: next_ch_finder (combinational).
  - Inputs: mask, current sel, a "first" flag.
  - Outputs: next enabled channel index and a "none_left" flag.
  - Used both for the start selection and for advancing.

Test Plan:
1. Bench instantiates mux + sampler with I=4'b1010, ch_mask=4'hF, dwell=0, pulse start.
   -> sel 0,1,2,3 on consecutive cycles; frame_valid high 4 cycles after start; frame=4'b1010; busy high exactly 4 cycles.
2. I=4'b1111, ch_mask=4'b0101, dwell=2.
   -> sel=0 for 3 cycles, then sel=2 for 3 cycles; frame=4'b0101 with valid 6 cycles after start.
3. ch_mask=0, start.
   -> busy never asserts; frame=0 and frame_valid pulse in the next cycle.
4. Concurrency cases:
   - start re-pulsed mid-scan with different mask -> ignored; frame matches the original mask.
   - start held in the frame_valid cycle -> second scan begins immediately, sel restarts at the lowest enabled channel.
   - I toggled during a dwell=3 hold -> the value present at the final hold edge is captured.
5. rst asserted on cycle 2 of a dwell=3, full-mask scan.
   -> next cycle sel=0, busy=0, frame=0; no frame_valid until a new start.
   - Repeat with rst and start high together -> stays in IDLE.
6. dwell=4'hF, ch_mask=4'b1000.
   -> sel=3 held exactly 16 cycles; frame_valid 16 cycles after start; frame=I[3]<<3.
